// File: rtl/alu_issue_stage.sv
// Decode-to-execute stage: RV32I ALU decode into a single-entry ID/EX register.
// Define ALU_ISSUE_ILLEGAL_EN to forward unsupported instructions flagged illegal.
module alu_issue_stage #(
  parameter bit SUPPRESS_X0_WB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [4:0]  rd;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd    = in_instr[11:7];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'h000};

  // rs1 index is resolved upstream by the register-file read
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^in_instr[19:15];

  logic       f3_ok;
  logic [2:0] f3_op;

  always_comb begin
    f3_ok = 1'b1;
    f3_op = OP_ADD;
    case (f3)
      3'b000:  f3_op = OP_ADD;
      3'b111:  f3_op = OP_AND;
      3'b110:  f3_op = OP_OR;
      3'b100:  f3_op = OP_XOR;
      3'b001:  f3_op = OP_SLL;
      3'b101:  f3_op = OP_SRL;
      3'b010:  f3_op = OP_SLT;
      default: f3_ok = 1'b0;
    endcase
  end

  logic        is_r;
  logic        is_i;
  logic        is_lui;
  logic        is_auipc;
  logic        shift_f3;

  assign is_r     = (opc == OPC_R);
  assign is_i     = (opc == OPC_I);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign shift_f3 = (f3 == 3'b001) || (f3 == 3'b101);

  logic        dec_legal;
  logic [2:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_a     = 32'h0;
    dec_b     = 32'h0;
    unique case (1'b1)
      is_r: begin
        dec_a = in_rs1_data;
        dec_b = in_rs2_data;
        if (f7 == 7'b0000000) begin
          dec_legal = f3_ok;
          dec_op    = f3_op;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end
      end
      is_i: begin
        dec_a     = in_rs1_data;
        dec_b     = imm_i;
        dec_op    = f3_op;
        dec_legal = f3_ok && (!shift_f3 || f7 == 7'b0);
      end
      is_lui: begin
        dec_legal = 1'b1;
        dec_b     = imm_u;
      end
      is_auipc: begin
        dec_legal = 1'b1;
        dec_a     = in_pc;
        dec_b     = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    // illegal entries present zeroed operands and ADD
    if (!dec_legal) begin
      dec_op = OP_ADD;
      dec_a  = 32'h0;
      dec_b  = 32'h0;
    end
  end

  logic dec_wb;
  assign dec_wb = dec_legal && !(SUPPRESS_X0_WB && rd == 5'd0);

  logic load_ok;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign load_ok = 1'b1;
`else
  assign load_ok = dec_legal;
`endif

  logic        valid_q;
  logic        valid_d;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        wb_q;
  logic        xfer;

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (xfer)      valid_d = load_ok;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= 3'b000;
      rd_q    <= 5'd0;
      wb_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (xfer && !flush) begin
        a_q  <= dec_a;
        b_q  <= dec_b;
        op_q <= dec_op;
        rd_q <= rd;
        wb_q <= dec_wb;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (rst)                ill_q <= 1'b0;
    else if (xfer && !flush) ill_q <= !dec_legal;
  end
  assign out_illegal = ill_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid  = valid_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_alu_op = op_q;
  assign out_rd     = rd_q;
  assign out_wb_en  = wb_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed test-plan cases then random traffic
// checked against a transaction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic        legal;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } ent_t;

  int   n_chk = 0;
  int   n_err = 0;
  logic m_valid;
  logic m_pristine;
  ent_t m_e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] u_ins(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Mnemonic-level reference: returns -1 for unsupported f3 values
  function automatic int op_of_f3(input logic [2:0] f3);
    case (f3)
      3'd0: return 0;
      3'd7: return 2;
      3'd6: return 3;
      3'd4: return 4;
      3'd1: return 5;
      3'd5: return 6;
      3'd2: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic ent_t ref_decode(input logic [31:0] ins,
    input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    int   op;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    op = -1;
    e.a = 0; e.b = 0; e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) op = op_of_f3(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
        e.a = r1; e.b = r2;
      end
      7'h13: begin
        op = op_of_f3(f3);
        if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) op = -1;
        e.a = r1; e.b = 32'($signed(ins[31:20]));
      end
      7'h37: begin op = 0; e.a = 0; e.b = {ins[31:12], 12'h0}; end
      7'h17: begin op = 0; e.a = pc; e.b = {ins[31:12], 12'h0}; end
      default: op = -1;
    endcase
    e.legal = (op >= 0);
    if (e.legal) begin
      e.op  = 3'(op);
      e.wb  = (e.rd != 0);
      e.ill = 1'b0;
    end else begin
      e.op = 0; e.a = 0; e.b = 0; e.wb = 0; e.ill = 1'b1;
    end
    return e;
  endfunction

  // Entered just after a falling edge; leaves just after the next one.
  task automatic step(input logic v, input logic [31:0] ins,
    input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
    input logic ordy, input logic fl, input logic rs);
    ent_t e;
    logic xfer;
    in_valid = v; in_instr = ins; in_pc = pc;
    in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || m_pristine) begin
      chk("a", out_a, m_e.a);
      chk("b", out_b, m_e.b);
      chk("op", 32'(out_alu_op), 32'(m_e.op));
      chk("rd", 32'(out_rd), 32'(m_e.rd));
      chk("wb", 32'(out_wb_en), 32'(m_e.wb));
      chk("ill", 32'(out_illegal), 32'(m_e.ill && ILL_EN));
    end
    e = ref_decode(ins, pc, r1, r2);
    xfer = v && (!m_valid || ordy);
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_pristine = 1;
      m_e = '{legal: 0, op: 0, a: 0, b: 0, rd: 0, wb: 0, ill: 0};
    end else if (fl) begin
      m_valid = 0;
    end else if (xfer) begin
      m_pristine = 0;
      m_valid = e.legal || ILL_EN;
      if (m_valid) m_e = e;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    #1;
  endtask

  logic [31:0] ins;
  logic [6:0]  opc;

  initial begin
    m_valid = 0; m_pristine = 1;
    m_e = '{legal: 0, op: 0, a: 0, b: 0, rd: 0, wb: 0, ill: 0};
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_a", out_a, 0);

    // ADD x3,x1,x2
    step(1, r_ins(7'h00, 2, 1, 3'd0, 3), 0, 5, 7, 1, 0, 0);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_op", 32'(out_alu_op), 0);
    chk("add_a", out_a, 5);
    chk("add_b", out_b, 7);
    chk("add_rd", 32'(out_rd), 3);
    chk("add_wb", 32'(out_wb_en), 1);

    // SUB then ADDI back-to-back
    step(1, r_ins(7'h20, 2, 1, 3'd0, 4), 0, 5, 7, 1, 0, 0);
    chk("sub_op", 32'(out_alu_op), 1);
    chk("sub_b", out_b, 7);
    step(1, i_ins(12'hFFF, 1, 3'd0, 6), 0, 5, 7, 1, 0, 0);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_b", out_b, 32'hFFFF_FFFF);

    // LUI then AUIPC
    step(1, u_ins(20'h12345, 5, 7'h37), 0, 9, 9, 1, 0, 0);
    chk("lui_a", out_a, 0);
    chk("lui_b", out_b, 32'h1234_5000);
    step(1, u_ins(20'h00001, 7, 7'h17), 32'h100, 9, 9, 1, 0, 0);
    chk("auipc_a", out_a, 32'h100);
    chk("auipc_b", out_b, 32'h1000);

    // Stall with held SLT entry
    step(1, r_ins(7'h00, 3, 2, 3'd2, 8), 0, 32'hFFFF_FFF0, 4, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, r_ins(7'h00, 5, 6, 3'd0, 9), 0, 11, 22, 0, 0, 0);
      chk("stall_rdy", 32'(in_ready), 0);
      chk("stall_op", 32'(out_alu_op), 7);
    end
    step(1, r_ins(7'h00, 5, 6, 3'd0, 9), 0, 11, 22, 1, 0, 0);
    chk("unstall_op", 32'(out_alu_op), 0);
    chk("unstall_a", out_a, 11);

    // Flush on transfer, then ADDI x0
    step(1, r_ins(7'h00, 3, 2, 3'd4, 1), 0, 1, 2, 1, 1, 0);
    chk("flush_valid", 32'(out_valid), 0);
    step(1, i_ins(12'h000, 0, 3'd0, 0), 0, 0, 0, 1, 0, 0);
    chk("x0_valid", 32'(out_valid), 1);
    chk("x0_wb", 32'(out_wb_en), 0);

    // SRA x1,x2,x3
    step(1, r_ins(7'h20, 3, 2, 3'd5, 1), 0, 1, 2, 1, 0, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("sra_valid", 32'(out_valid), 1);
    chk("sra_ill", 32'(out_illegal), 1);
    chk("sra_wb", 32'(out_wb_en), 0);
`else
    chk("sra_valid", 32'(out_valid), 0);
    chk("sra_ready", 32'(in_ready), 1);
`endif

    // Reset mid-stall
    step(1, r_ins(7'h00, 3, 2, 3'd2, 8), 0, 3, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rststall_valid", 32'(out_valid), 0);

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 5))
        0, 1: opc = 7'h33;
        2, 3: opc = 7'h13;
        4:    opc = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
        default: opc = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = opc;
      if ($urandom_range(0, 3) != 0)
        ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 0;
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
